// File: rtl/link_emu_pkg.sv
// Shared defaults and elaboration-time parameter checks for the link latency emulator.
package link_emu_pkg;

    localparam int DEFAULT_WIDTH   = 64;
    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_LATENCY = 2;  // matches the bench ROUTER_DELAY
    localparam int DEFAULT_CNT_W   = 32;

    // DEPTH must be a power of two (pointers wrap by natural overflow) and LATENCY at least one cycle.
    function automatic bit params_ok(input int depth, input int latency);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) && (latency >= 1);
    endfunction

endpackage

// File: rtl/link_latency_emulator_if.sv
// Word stream into and out of the link latency emulator.
// Handshake: a word transfers on a rising clk edge where valid && ready; a source holding valid
// keeps its data stable until that edge, and ready never waits on valid.
interface link_latency_emulator_if
    import link_emu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] input_data;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] output_data;
    logic             output_valid;
    logic             output_ready;

    modport master (
        output input_data,
        output input_valid,
        input  input_ready,
        input  output_data,
        input  output_valid,
        output output_ready
    );

    modport slave (
        input  input_data,
        input  input_valid,
        output input_ready,
        output output_data,
        output output_valid,
        input  output_ready
    );
endinterface

// File: rtl/link_emu_slot.sv
// One buffer slot: a data register plus a saturating wait counter that marks when the word has matured.
module link_emu_slot
    import link_emu_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    parameter  int LATENCY = DEFAULT_LATENCY,
    localparam int WAIT_W  = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             decrement,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             matured
);

    logic [WAIT_W-1:0] wait_count;

    // The load value is LATENCY-1 because the edge that writes the slot is itself one cycle of delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= '0;
            wait_count <= '0;
        end else if (load) begin
            data       <= load_data;
            wait_count <= WAIT_W'(LATENCY - 1);
        end else if (clear) begin
            data       <= '0;
            wait_count <= '0;
        end else if (decrement && (wait_count != '0)) begin
            wait_count <= wait_count - WAIT_W'(1);
        end
    end

    assign matured = (wait_count == '0);

endmodule

// File: rtl/link_latency_emulator.sv
// Order-preserving fixed-latency delay stage for one grid link word stream, with occupancy and forwarded-word statistics.
module link_latency_emulator
    import link_emu_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    parameter  int DEPTH   = DEFAULT_DEPTH,
    parameter  int LATENCY = DEFAULT_LATENCY,
    parameter  int CNT_W   = DEFAULT_CNT_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    link_latency_emulator_if.slave link,
    output logic [OCC_W-1:0]     occupancy,
    output logic [CNT_W-1:0]     forwarded_count
);

    if (!params_ok(DEPTH, LATENCY)) begin : g_param_check
        $error("link_latency_emulator: DEPTH must be a power of two >= 2 and LATENCY >= 1");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0] slot_matured;
    logic [DEPTH-1:0] slot_load;
    logic [DEPTH-1:0] slot_clear;
    logic [DEPTH-1:0] slot_dec;

    // No full-buffer bypass: a full buffer refuses input even when the head is leaving this cycle.
    assign link.input_ready  = (count != OCC_W'(DEPTH)) && !reset;
    assign link.output_valid = (count != '0) && slot_matured[rd_ptr];
    assign link.output_data  = slot_data[rd_ptr];

    assign push = link.input_valid && link.input_ready;
    assign pop  = link.output_valid && link.output_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] offset;
        logic             occupied;

        // A slot is occupied when its distance past the read pointer is below the count.
        assign offset       = PTR_W'(g) - rd_ptr;
        assign occupied     = (OCC_W'(offset) < count);
        assign slot_load[g] = push && (wr_ptr == PTR_W'(g));
        assign slot_clear[g] = pop && (rd_ptr == PTR_W'(g));
        assign slot_dec[g]  = occupied && !slot_load[g];

        link_emu_slot #(
            .WIDTH   (WIDTH),
            .LATENCY (LATENCY)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (slot_load[g]),
            .decrement (slot_dec[g]),
            .clear     (slot_clear[g]),
            .load_data (link.input_data),
            .data      (slot_data[g]),
            .matured   (slot_matured[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            forwarded_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                forwarded_count <= forwarded_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign occupancy = count;

endmodule
